mem_arbiter: RTL

- Shares the single off-chip memory port (28-bit line address, 128-bit line data) between the I-cache and D-cache memory interfaces.
- Each cache holds read/write with address and data until it sees a one-cycle ready pulse; the arbiter grants one cache at a time, using round-robin on contention.
- Sits between the two cache controllers and the memory model; it also provides per-client completion counters and sticky error flags for debug.

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-side signals around mem_arbiter.
// slave: arbiter view; master: caches + memory model view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
);
  logic              mem_read_I;
  logic              mem_write_I;
  logic [ADDR_W-1:0] mem_addr_I;
  logic [DATA_W-1:0] mem_wdata_I;
  logic [DATA_W-1:0] mem_rdata_I;
  logic              mem_ready_I;

  logic              mem_read_D;
  logic              mem_write_D;
  logic [ADDR_W-1:0] mem_addr_D;
  logic [DATA_W-1:0] mem_wdata_D;
  logic [DATA_W-1:0] mem_rdata_D;
  logic              mem_ready_D;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic [CNT_W-1:0]  cnt_I;
  logic [CNT_W-1:0]  cnt_D;
  logic              proto_err;
  logic              timeout_err;

  modport slave (
    input  mem_read_I, mem_write_I, mem_addr_I, mem_wdata_I,
    input  mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D,
    input  mem_rdata, mem_ready,
    output mem_rdata_I, mem_ready_I, mem_rdata_D, mem_ready_D,
    output mem_read, mem_write, mem_addr, mem_wdata,
    output cnt_I, cnt_D, proto_err, timeout_err
  );

  modport master (
    output mem_read_I, mem_write_I, mem_addr_I, mem_wdata_I,
    output mem_read_D, mem_write_D, mem_addr_D, mem_wdata_D,
    output mem_rdata, mem_ready,
    input  mem_rdata_I, mem_ready_I, mem_rdata_D, mem_ready_D,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    input  cnt_I, cnt_D, proto_err, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between I- and D-cache; grant one cycle
// after request, request held by the cache until its ready pulse, one RELEASE gap per transaction.
module mem_arbiter #(
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 128,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              last_q, last_d;      // 1: D was granted last
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_i_q, cnt_i_d;
  logic [CNT_W-1:0]  cnt_d_q, cnt_d_d;
  logic              perr_q, perr_d;
  logic              terr_q, terr_d;

  logic req_i, req_d, busy, sel_d, g_read, g_write;

  assign req_i   = bus.mem_read_I | bus.mem_write_I;
  assign req_d   = bus.mem_read_D | bus.mem_write_D;
  assign busy    = (state_q == BUSY_I) || (state_q == BUSY_D);
  assign sel_d   = (state_q == BUSY_D);
  assign g_read  = sel_d ? bus.mem_read_D  : bus.mem_read_I;
  assign g_write = sel_d ? bus.mem_write_D : bus.mem_write_I;

  // A client raising read and write together gets a write only.
  assign bus.mem_read  = busy & g_read & ~g_write;
  assign bus.mem_write = busy & g_write;
  assign bus.mem_addr  = busy ? (sel_d ? bus.mem_addr_D  : bus.mem_addr_I)  : '0;
  assign bus.mem_wdata = busy ? (sel_d ? bus.mem_wdata_D : bus.mem_wdata_I) : '0;

  assign bus.mem_ready_I = (state_q == BUSY_I) & bus.mem_ready;
  assign bus.mem_ready_D = (state_q == BUSY_D) & bus.mem_ready;
  assign bus.mem_rdata_I = (state_q == BUSY_I) ? bus.mem_rdata : '0;
  assign bus.mem_rdata_D = (state_q == BUSY_D) ? bus.mem_rdata : '0;

  assign bus.cnt_I       = cnt_i_q;
  assign bus.cnt_D       = cnt_d_q;
  assign bus.proto_err   = perr_q;
  assign bus.timeout_err = terr_q;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    wait_d  = wait_q;
    cnt_i_d = cnt_i_q;
    cnt_d_d = cnt_d_q;
    perr_d  = perr_q;
    terr_d  = terr_q;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (req_i && (!req_d || last_q)) begin
          state_d = BUSY_I;
          last_d  = 1'b0;
        end else if (req_d) begin
          state_d = BUSY_D;
          last_d  = 1'b1;
        end
      end
      BUSY_I, BUSY_D: begin
        if (g_read && g_write) perr_d = 1'b1;
        if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
        // Flag only; the transaction keeps waiting for memory.
        if (wait_q >= WAIT_LAST) terr_d = 1'b1;
        if (bus.mem_ready) begin
          state_d = RELEASE;
          if (sel_d) begin
            if (cnt_d_q != '1) cnt_d_d = cnt_d_q + 1'b1;
          end else begin
            if (cnt_i_q != '1) cnt_i_d = cnt_i_q + 1'b1;
          end
        end else if (!(g_read || g_write)) begin
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      wait_q  <= '0;
      cnt_i_q <= '0;
      cnt_d_q <= '0;
      perr_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      cnt_i_q <= cnt_i_d;
      cnt_d_q <= cnt_d_d;
      perr_q  <= perr_d;
      terr_q  <= terr_d;
    end
  end

endmodule
